// File: rtl/playtime_bcd_counter.sv
// Elapsed-playback timer: MM:SS in four BCD digits, advanced once per CLK_HZ cycles of Play.
// Freezes at MAX_MIN:59 and emits a registered one-cycle tick on each seconds increment.
module playtime_bcd_counter #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned MAX_MIN = 99
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Play,
  input  logic       Clear,
  output logic [3:0] Sec_Ones,
  output logic [3:0] Sec_Tens,
  output logic [3:0] Min_Ones,
  output logic [3:0] Min_Tens,
  output logic       Sec_Tick,
  output logic       Saturated
);

  localparam int unsigned PreW = $clog2(CLK_HZ);
  localparam logic [PreW-1:0] PreLast = PreW'(CLK_HZ - 1);
  localparam logic [PreW-1:0] PreOne  = PreW'(1);
  localparam logic [3:0] MaxMinTens = 4'(MAX_MIN / 10);
  localparam logic [3:0] MaxMinOnes = 4'(MAX_MIN % 10);

  logic [PreW-1:0] pre_q, pre_d;
  logic [3:0]      sec_ones_q, sec_ones_d;
  logic [3:0]      sec_tens_q, sec_tens_d;
  logic [3:0]      min_ones_q, min_ones_d;
  logic [3:0]      min_tens_q, min_tens_d;
  logic            tick_q, tick_d;
  logic            sat_q, sat_d;

  // Digits one second ahead of the current count.
  logic [3:0] adv_sec_ones, adv_sec_tens, adv_min_ones, adv_min_tens;

  always_comb begin
    adv_sec_ones = sec_ones_q;
    adv_sec_tens = sec_tens_q;
    adv_min_ones = min_ones_q;
    adv_min_tens = min_tens_q;
    if (sec_ones_q != 4'd9) begin
      adv_sec_ones = sec_ones_q + 4'd1;
    end else begin
      adv_sec_ones = 4'd0;
      if (sec_tens_q != 4'd5) begin
        adv_sec_tens = sec_tens_q + 4'd1;
      end else begin
        adv_sec_tens = 4'd0;
        if (min_ones_q != 4'd9) begin
          adv_min_ones = min_ones_q + 4'd1;
        end else begin
          adv_min_ones = 4'd0;
          adv_min_tens = (min_tens_q == 4'd9) ? 4'd0 : min_tens_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    pre_d      = pre_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    tick_d     = 1'b0;
    sat_d      = sat_q;
    if (Clear) begin
      pre_d      = '0;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
      sat_d      = 1'b0;
    end else if (sat_q) begin
      pre_d = '0;
    end else if (Play) begin
      if (pre_q == PreLast) begin
        pre_d      = '0;
        sec_ones_d = adv_sec_ones;
        sec_tens_d = adv_sec_tens;
        min_ones_d = adv_min_ones;
        min_tens_d = adv_min_tens;
        tick_d     = 1'b1;
        sat_d      = ({adv_min_tens, adv_min_ones, adv_sec_tens, adv_sec_ones} ==
                      {MaxMinTens, MaxMinOnes, 4'd5, 4'd9});
      end else begin
        pre_d = pre_q + PreOne;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_q      <= '0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      tick_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      tick_q     <= tick_d;
      sat_q      <= sat_d;
    end
  end

  assign Sec_Ones  = sec_ones_q;
  assign Sec_Tens  = sec_tens_q;
  assign Min_Ones  = min_ones_q;
  assign Min_Tens  = min_tens_q;
  assign Sec_Tick  = tick_q;
  assign Saturated = sat_q;

endmodule

// File: tb/tb_playtime_bcd_counter.sv
// Bench for playtime_bcd_counter: two instances (4 Hz / 99 min and 2 Hz / 1 min) share stimulus;
// a seconds-total model queues expected ticks, a negedge monitor pops and compares them.
module tb_playtime_bcd_counter;

  logic       Clk;
  logic       Reset_n;
  logic       Play;
  logic       Clear;
  logic [3:0] so [2];
  logic [3:0] st [2];
  logic [3:0] mo [2];
  logic [3:0] mt [2];
  logic       tick [2];
  logic       sat [2];

  playtime_bcd_counter #(.CLK_HZ(4), .MAX_MIN(99)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .Play(Play), .Clear(Clear),
    .Sec_Ones(so[0]), .Sec_Tens(st[0]), .Min_Ones(mo[0]), .Min_Tens(mt[0]),
    .Sec_Tick(tick[0]), .Saturated(sat[0])
  );

  playtime_bcd_counter #(.CLK_HZ(2), .MAX_MIN(1)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .Play(Play), .Clear(Clear),
    .Sec_Ones(so[1]), .Sec_Tens(st[1]), .Min_Ones(mo[1]), .Min_Tens(mt[1]),
    .Sec_Tick(tick[1]), .Saturated(sat[1])
  );

  typedef struct {
    int inst;
    int cyc;
    int secs;
  } exp_t;

  exp_t sb[$];
  int   hz_m [2] = '{4, 2};
  int   mx_m [2] = '{99, 1};
  int   pre_m [2] = '{0, 0};
  int   secs_m [2] = '{0, 0};
  bit   sat_m [2] = '{1'b0, 1'b0};
  int   tick_cnt [2] = '{0, 0};
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic int to_digits(input int s);
    int m;
    int x;
    m = s / 60;
    x = s % 60;
    return (m / 10) * 1000 + (m % 10) * 100 + (x / 10) * 10 + (x % 10);
  endfunction

  function automatic int dut_val(input int k);
    return int'(mt[k]) * 1000 + int'(mo[k]) * 100 + int'(st[k]) * 10 + int'(so[k]);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: tracks total seconds, pushes an expected tick whenever a second elapses.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        for (int k = 0; k < 2; k++) begin
          pre_m[k]  = 0;
          secs_m[k] = 0;
          sat_m[k]  = 1'b0;
        end
        sb.delete();
      end else begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
          if (Clear) begin
            pre_m[k]  = 0;
            secs_m[k] = 0;
            sat_m[k]  = 1'b0;
          end else if (sat_m[k]) begin
            pre_m[k] = 0;
          end else if (Play) begin
            if (pre_m[k] == hz_m[k] - 1) begin
              pre_m[k] = 0;
              secs_m[k]++;
              e.inst = k;
              e.cyc  = cyc;
              e.secs = secs_m[k];
              sb.push_back(e);
              if (secs_m[k] == mx_m[k] * 60 + 59) sat_m[k] = 1'b1;
            end else begin
              pre_m[k]++;
            end
          end
        end
      end
    end
  end

  // Monitor: per-cycle state compare plus scoreboard pop on every observed tick.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("digits_%0d", k), dut_val(k), to_digits(secs_m[k]));
        chk($sformatf("legal_%0d", k),
            int'(so[k] <= 4'd9 && st[k] <= 4'd5 && mo[k] <= 4'd9 && mt[k] <= 4'd9), 1);
        chk($sformatf("sat_%0d", k), int'(sat[k]), int'(sat_m[k]));
        if (tick[k]) begin
          tick_cnt[k]++;
          if (sb.size() == 0) begin
            chk($sformatf("spurious_tick_%0d", k), 1, 0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("tick_inst_%0d", k), k, e.inst);
            chk($sformatf("tick_cycle_%0d", k), cyc, e.cyc);
            chk($sformatf("tick_digits_%0d", k), dut_val(k), to_digits(e.secs));
          end
        end
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk($sformatf("missed_tick_%0d", e.inst), 0, 1);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    run(1);
    Clear = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    Reset_n = 1'b0;
    Play    = 1'b0;
    Clear   = 1'b0;
    run(3);
    chk("reset_digits", dut_val(0), 0);
    chk("reset_tick", int'(tick[0]), 0);
    chk("reset_sat", int'(sat[0]), 0);
    Reset_n = 1'b1;

    // Basic count
    t0 = tick_cnt[0];
    t1 = tick_cnt[1];
    Play = 1'b1;
    run(40);
    chk("basic_ticks_a", tick_cnt[0] - t0, 10);
    chk("basic_digits_a", dut_val(0), 10);
    chk("basic_ticks_b", tick_cnt[1] - t1, 20);
    chk("basic_digits_b", dut_val(1), 20);
    Play = 1'b0;
    do_clear();
    chk("clear_digits_a", dut_val(0), 0);

    // Pause / resume keeps the partial second
    Play = 1'b1;
    run(2);
    Play = 1'b0;
    t0 = tick_cnt[0];
    run(10);
    chk("pause_hold_a", dut_val(0), 0);
    chk("pause_ticks_a", tick_cnt[0] - t0, 0);
    Play = 1'b1;
    run(1);
    chk("resume_early_a", tick_cnt[0] - t0, 0);
    run(1);
    chk("resume_tick_a", tick_cnt[0] - t0, 1);
    chk("resume_tick_now_a", int'(tick[0]), 1);
    chk("resume_digits_a", dut_val(0), 1);
    chk("resume_digits_b", dut_val(1), 2);

    // Clear collides with terminal prescaler
    do_clear();
    run(3);
    Clear = 1'b1;
    run(1);
    Clear = 1'b0;
    chk("collide_digits_a", dut_val(0), 0);
    chk("collide_tick_a", int'(tick[0]), 0);
    t0 = tick_cnt[0];
    run(3);
    chk("collide_wait_a", tick_cnt[0] - t0, 0);
    run(1);
    chk("collide_next_a", tick_cnt[0] - t0, 1);
    chk("collide_digits2_a", dut_val(0), 1);

    // Play drops while prescaler is terminal
    do_clear();
    run(3);
    Play = 1'b0;
    t0 = tick_cnt[0];
    run(5);
    chk("playfall_ticks_a", tick_cnt[0] - t0, 0);
    chk("playfall_digits_a", dut_val(0), 0);
    Play = 1'b1;
    run(1);
    chk("playfall_resume_a", tick_cnt[0] - t0, 1);
    chk("playfall_digits2_a", dut_val(0), 1);

    // Reset mid-count at 03:27
    do_clear();
    t1 = tick_cnt[1];
    run(828);
    chk("run_0327_a", dut_val(0), 327);
    chk("run_sat_b", int'(sat[1]), 1);
    chk("run_digits_b", dut_val(1), 159);
    chk("run_ticks_b", tick_cnt[1] - t1, 119);
    run(2);
    chk("midsec_a", dut_val(0), 327);
    Reset_n = 1'b0;
    #1;
    chk("async_rst_digits_a", dut_val(0), 0);
    chk("async_rst_tick_a", int'(tick[0]), 0);
    chk("async_rst_sat_b", int'(sat[1]), 0);
    chk("async_rst_digits_b", dut_val(1), 0);
    run(2);
    Reset_n = 1'b1;
    t0 = tick_cnt[0];
    run(3);
    chk("post_rst_wait_a", tick_cnt[0] - t0, 0);
    run(1);
    chk("post_rst_tick_a", tick_cnt[0] - t0, 1);

    // Saturation of the 1-minute instance, then clear and resume
    do_clear();
    t1 = tick_cnt[1];
    run(300);
    chk("sat_flag_b", int'(sat[1]), 1);
    chk("sat_digits_b", dut_val(1), 159);
    chk("sat_ticks_b", tick_cnt[1] - t1, 119);
    chk("sat_run_a", dut_val(0), 115);
    do_clear();
    chk("sat_clear_b", dut_val(1), 0);
    chk("sat_clear_flag_b", int'(sat[1]), 0);
    run(2);
    chk("sat_resume_b", dut_val(1), 1);

    // Carry chain on the 4 Hz instance
    do_clear();
    run(236);
    chk("carry_0059", dut_val(0), 59);
    run(4);
    chk("carry_0100", dut_val(0), 100);
    run(2156);
    chk("carry_0959", dut_val(0), 959);
    run(4);
    chk("carry_1000", dut_val(0), 1000);

    // Full-range saturation at 99:59
    do_clear();
    run(23996);
    chk("sat_digits_a", dut_val(0), 9959);
    chk("sat_flag_a", int'(sat[0]), 1);
    t0 = tick_cnt[0];
    run(40);
    chk("sat_frozen_a", dut_val(0), 9959);
    chk("sat_noticks_a", tick_cnt[0] - t0, 0);

    Play = 1'b0;
    run(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
